seq_magnitude_comparator: RTL and testbench
===========================================

Name: seq_magnitude_comparator

Overview:
- Parametrised, bit-serial successor to the team's 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands starting at the MSB, one bit per clock.
- Stops at the first differing bit and reports greater/equal/less, plus the index of the deciding bit.
- Supports unsigned and two's-complement signed modes, with a start/busy/done handshake for use by sequential datapath and sort/search controllers.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2 to 64.
- IDX_W, $clog2(WIDTH), width of diff_idx.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a comparison; accepted only when busy=0
- signed_mode  input  1  0 = unsigned, 1 = two's complement; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- busy  output  1  comparison in progress
- done  output  1  one-cycle pulse when result outputs update
- A_greater  output  1  A > B for the last completed comparison
- A_equal  output  1  A == B for the last completed comparison
- A_less  output  1  A < B for the last completed comparison
- diff_idx  output  IDX_W  index of the most significant differing bit; 0 when equal

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy, done, A_greater, A_equal, A_less and diff_idx are all 0. Reset has priority over every other input, including mid-comparison; any in-flight result is discarded and no done pulse is produced.
- States: IDLE, CMP, DONE. All outputs are registered.
- IDLE:
  - If start=1, latch A, B and signed_mode, set bit index to WIDTH-1, go to CMP.
  - busy=1 from the next cycle.
- CMP, examining latched bit i:
  - Bits differ: decide greater when A[i]=1, less when A[i]=0. Exception: when signed_mode=1 and i=WIDTH-1, the sense is inverted (A[MSB]=1 means A is negative, so A < B). Load the flags and diff_idx=i, go to DONE.
  - Bits equal and i>0: decrement i, stay in CMP.
  - Bits equal and i=0: A_equal=1, diff_idx=0, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - New flag and diff_idx values become visible in the same cycle as done.
  - Next state is IDLE, unless start=1 in this cycle; then the new operands are latched and the next state is CMP (back-to-back operation).
- Latency: with start sampled at edge t and deciding bit p (p=0 for equal), done is high in cycle t+WIDTH+1-p.
  - Minimum is 2 cycles (MSB differs).
  - Maximum is WIDTH+1 cycles (equal operands, or only the LSB differs).
- start while busy=1 is ignored. Operand and mode inputs are don't-care while busy.
- Result flags hold their last values until the next done.
  - After the first done, exactly one of A_greater, A_equal and A_less is 1.
  - Before the first done after reset, all three are 0.
- Signed mode affects only the MSB decision. Lower bits compare identically in both modes.

Test Plan (WIDTH=8):
1. Unsigned, A=0xC4, B=0x94, start at edge t -> done at t+3; A_greater=1, A_equal=0, A_less=0; diff_idx=6; busy high on cycles t+1..t+2.
2. A=B=0x5A -> done at t+9; A_equal=1, diff_idx=0. Then A=0x5B, B=0x5A -> done at t+9; A_greater=1, diff_idx=0.
3. A=0x80, B=0x01:
   - signed_mode=1 -> done at t+2; A_less=1, diff_idx=7.
   - Repeat with signed_mode=0 -> A_greater=1, diff_idx=7.
4. Handshake:
   - Start A=0x10, B=0x20; pulse start again with A=0xFF, B=0x00 while busy -> ignored; result is A_less=1, diff_idx=5.
   - Assert start with A=0x03, B=0x03 in the done cycle -> accepted; the next done reports A_equal=1 with no IDLE gap.
5. Start A=0x01, B=0x00; assert rst at cycle t+4 -> no done pulse; all outputs 0 the cycle after reset; the next start completes normally.
6. Randomised sweep of 1000 operand pairs in both modes -> flags match a reference compare; diff_idx equals the MSB index of A^B; done latency matches t+WIDTH+1-p.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial magnitude comparator: walks two operands MSB-first, one bit per clock,
// and reports greater/equal/less plus the index of the deciding bit.
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_greater,
    output logic             A_equal,
    output logic             A_less,
    output logic [IDX_W-1:0] diff_idx
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             sm_p0;
    logic [IDX_W-1:0] idx_p0;

    logic             load;
    logic             bit_a;
    logic             bits_differ;
    logic             at_msb;
    logic             decide;

    // In signed mode a set MSB marks a negative value, so the sense flips there only.
    function automatic logic a_wins(input logic a_bit, input logic is_msb, input logic sm);
        return (sm && is_msb) ? ~a_bit : a_bit;
    endfunction

    assign bit_a       = a_p0[idx_p0];
    assign bits_differ = bit_a ^ b_p0[idx_p0];
    assign at_msb      = (idx_p0 == IDX_MSB);
    assign decide      = (state == CMP) && (state_next == DONE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CMP;
                end
            end
            CMP: begin
                if (bits_differ || (idx_p0 == IDX_ZERO)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CMP;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            A_greater <= 1'b0;
            A_equal   <= 1'b0;
            A_less    <= 1'b0;
            diff_idx  <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == CMP);
            done  <= (state_next == DONE);
            if (decide) begin
                if (bits_differ) begin
                    A_greater <= a_wins(bit_a, at_msb, sm_p0);
                    A_equal   <= 1'b0;
                    A_less    <= ~a_wins(bit_a, at_msb, sm_p0);
                    diff_idx  <= idx_p0;
                end else begin
                    A_greater <= 1'b0;
                    A_equal   <= 1'b1;
                    A_less    <= 1'b0;
                    diff_idx  <= '0;
                end
            end
        end
    end

    // Operand datapath: loaded on accept, index walks down while bits match.
    always_ff @(posedge clk) begin
        if (load) begin
            a_p0   <= A;
            b_p0   <= B;
            sm_p0  <= signed_mode;
            idx_p0 <= IDX_MSB;
        end else if ((state == CMP) && !bits_differ && (idx_p0 != IDX_ZERO)) begin
            idx_p0 <= idx_p0 - IDX_ONE;
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed-vector and sweep bench for seq_magnitude_comparator at WIDTH=8.
module tb_seq_magnitude_comparator;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_mode;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          busy;
    logic          done;
    logic          A_greater;
    logic          A_equal;
    logic          A_less;
    logic [IW-1:0] diff_idx;

    int passed = 0;
    int total  = 0;

    seq_magnitude_comparator #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .A(A), .B(B), .busy(busy), .done(done),
        .A_greater(A_greater), .A_equal(A_equal), .A_less(A_less),
        .diff_idx(diff_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          sm;
        logic [2:0]    flags;   // {greater, equal, less}
        logic [IW-1:0] idx;
        int            lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Counts falling edges until done is seen; busy must be high on every earlier one.
    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n++;
            if (done) begin
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        @(negedge clk);
        A = a;
        B = b;
        signed_mode = sm;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sm, input logic [2:0] ef, input logic [IW-1:0] ei,
                           input int elat);
        int n;
        bit bok;
        logic [2:0] held;
        launch(a, b, sm);
        wait_done(n, bok);
        check({name, "_lat"}, n, elat);
        check({name, "_flags"}, {A_greater, A_equal, A_less}, ef);
        check({name, "_idx"}, diff_idx, ei);
        check({name, "_busy"}, bok, 1);
        held = {A_greater, A_equal, A_less};
        @(negedge clk);
        check({name, "_pulse"}, {done, busy, held}, {2'b00, ef});
    endtask

    initial begin
        int n;
        bit bok;
        int stray;
        logic [W-1:0] ra, rb, x;
        logic rsm;
        logic [2:0] ef;
        int p;

        vecs[0] = '{8'hC4, 8'h94, 1'b0, 3'b100, 3'd6, 3};
        vecs[1] = '{8'h5A, 8'h5A, 1'b0, 3'b010, 3'd0, 9};
        vecs[2] = '{8'h5B, 8'h5A, 1'b0, 3'b100, 3'd0, 9};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 3'b001, 3'd7, 2};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 3'b100, 3'd7, 2};
        vecs[5] = '{8'h7F, 8'h80, 1'b1, 3'b100, 3'd7, 2};
        vecs[6] = '{8'hFF, 8'hFE, 1'b1, 3'b100, 3'd0, 9};
        vecs[7] = '{8'h00, 8'h01, 1'b0, 3'b001, 3'd0, 9};
        vecs[8] = '{8'h10, 8'h20, 1'b0, 3'b001, 3'd5, 4};
        vecs[9] = '{8'hA5, 8'hA5, 1'b1, 3'b010, 3'd0, 9};

        rst = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", {busy, done, A_greater, A_equal, A_less, diff_idx}, 0);

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
                    vecs[i].flags, vecs[i].idx, vecs[i].lat);
        end

        // start pulsed while busy must be ignored
        launch(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        check("hs_busy", busy, 1);
        A = 8'hFF;
        B = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, bok);
        check("hs_lat", n, 3);
        check("hs_flags", {A_greater, A_equal, A_less}, 3'b001);
        check("hs_idx", diff_idx, 5);

        // start in the done cycle is accepted with no idle gap
        A = 8'h03;
        B = 8'h03;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n, bok);
        check("b2b_lat", n, 9);
        check("b2b_nogap", bok, 1);
        check("b2b_flags", {A_greater, A_equal, A_less}, 3'b010);
        check("b2b_idx", diff_idx, 0);

        // reset mid-comparison discards the result
        launch(8'h01, 8'h00, 1'b0);
        stray = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (done) stray++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {busy, done, A_greater, A_equal, A_less, diff_idx}, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) stray++;
        end
        check("rst_mid_nodone", stray, 0);
        run_vec("after_rst", 8'h01, 8'h00, 1'b0, 3'b100, 3'd0, 9);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) rb = ra;
            rsm = i[0];
            if (rsm) ef = ($signed(ra) > $signed(rb)) ? 3'b100 :
                          ($signed(ra) < $signed(rb)) ? 3'b001 : 3'b010;
            else     ef = (ra > rb) ? 3'b100 : (ra < rb) ? 3'b001 : 3'b010;
            x = ra ^ rb;
            p = 0;
            for (int k = 0; k < W; k++) if (x[k]) p = k;
            launch(ra, rb, rsm);
            wait_done(n, bok);
            check($sformatf("rnd%0d_lat", i), n, W + 1 - p);
            check($sformatf("rnd%0d_flags", i), {A_greater, A_equal, A_less}, ef);
            check($sformatf("rnd%0d_idx", i), diff_idx, p);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
